// File: rtl/sp_pkg.sv
// Shared types and constants for the simple processor.
// Holds widths, the memory-port arbiter states and its requester ids.
package sp_pkg;

  localparam int ADDR_WIDTH           = 16;
  localparam int DATA_WIDTH           = 16;
  localparam int ARB_MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF,
    ARB_LS
  } arb_state_e;

  typedef enum logic {
    REQ_IF,
    REQ_LS
  } requester_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Counts grant-state cycles without a memory ack.
// Flags expiry once the wait limit is reached.
module arb_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  logic [CntW-1:0] r_count;

  // Saturates at the limit so the counter never wraps while an abort is pending.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != MaxCnt)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == MaxCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for the
// single shared memory port, with a wait-limit abort.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = sp_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sp_pkg::DATA_WIDTH,
  parameter int MAX_WAIT   = sp_pkg::ARB_MAX_WAIT_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_ack_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_ack_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  grant_o,
  output logic                  timeout_o
);

  import sp_pkg::*;

  arb_state_e            r_state;
  arb_state_e            w_stateNext;
  requester_e            r_lastGrant;
  logic                  r_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ifAck;
  logic                  r_lsAck;
  logic [DATA_WIDTH-1:0] r_ifRdata;
  logic [DATA_WIDTH-1:0] r_lsRdata;
  logic                  r_timeout;

  logic w_ifReq;
  logic w_lsReq;
  logic w_grantIf;
  logic w_grantLs;
  logic w_done;
  logic w_abort;
  logic w_waitEn;
  logic w_expired;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A requester whose ack is showing this cycle is masked so its held
  // request is not mistaken for a new one.
  always_comb begin
    w_stateNext = r_state;
    w_grantIf   = 1'b0;
    w_grantLs   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    w_waitEn    = 1'b0;
    w_ifReq     = if_req_i & ~r_ifAck;
    w_lsReq     = ls_req_i & ~r_lsAck;
    case (r_state)
      ARB_IDLE: begin
        if (w_ifReq && w_lsReq) begin
          w_grantIf = (r_lastGrant == REQ_LS);
          w_grantLs = (r_lastGrant == REQ_IF);
        end else begin
          w_grantIf = w_ifReq;
          w_grantLs = w_lsReq;
        end
        if (w_grantIf) begin
          w_stateNext = ARB_IF;
        end else if (w_grantLs) begin
          w_stateNext = ARB_LS;
        end
      end
      ARB_IF, ARB_LS: begin
        w_waitEn = ~mem_ack_i;
        if (mem_ack_i) begin
          w_done      = 1'b1;
          w_stateNext = ARB_IDLE;
        end else if (w_expired) begin
          w_abort     = 1'b1;
          w_stateNext = ARB_IDLE;
        end
      end
      default: w_stateNext = ARB_IDLE;
    endcase
  end

  arb_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_waitTimer (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .clear   (w_grantIf | w_grantLs),
    .enable  (w_waitEn),
    .expired (w_expired)
  );

  // Captured request fields, completion pulses and returned data.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_lastGrant <= REQ_LS;
      r_grant     <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_ifAck     <= 1'b0;
      r_lsAck     <= 1'b0;
      r_ifRdata   <= '0;
      r_lsRdata   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_ifAck   <= 1'b0;
      r_lsAck   <= 1'b0;
      r_timeout <= 1'b0;
      if (w_grantIf) begin
        r_addr      <= if_addr_i;
        r_we        <= 1'b0;
        r_wdata     <= '0;
        r_lastGrant <= REQ_IF;
        r_grant     <= 1'b0;
      end else if (w_grantLs) begin
        r_addr      <= ls_addr_i;
        r_we        <= ls_we_i;
        r_wdata     <= ls_wdata_i;
        r_lastGrant <= REQ_LS;
        r_grant     <= 1'b1;
      end
      if (w_done) begin
        if (r_state == ARB_IF) begin
          r_ifAck   <= 1'b1;
          r_ifRdata <= mem_rdata_i;
        end else begin
          r_lsAck <= 1'b1;
          if (!r_we) begin
            r_lsRdata <= mem_rdata_i;
          end
        end
      end else if (w_abort) begin
        r_timeout <= 1'b1;
        if (r_state == ARB_IF) begin
          r_ifAck   <= 1'b1;
          r_ifRdata <= '0;
        end else begin
          r_lsAck   <= 1'b1;
          r_lsRdata <= '0;
        end
      end
    end
  end

  assign mem_req_o   = (r_state != ARB_IDLE);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign if_ack_o    = r_ifAck;
  assign if_rdata_o  = r_ifRdata;
  assign ls_ack_o    = r_lsAck;
  assign ls_rdata_o  = r_lsRdata;
  assign grant_o     = r_grant;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a simple delayed-ack memory.
module tb_mem_port_arbiter;

  localparam int AW   = sp_pkg::ADDR_WIDTH;
  localparam int DW   = sp_pkg::DATA_WIDTH;
  localparam int MAXW = 4;

  logic          clk_i = 1'b0;
  logic          arst_ni;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i;
  logic          ls_we_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic          ls_ack_o;
  logic [DW-1:0] ls_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;
  logic          grant_o;
  logic          timeout_o;

  typedef struct {
    logic          owner;
    logic [DW-1:0] rdata;
    logic          timeout;
    int            expCycle;
  } exp_t;

  exp_t expQ[$];
  exp_t curExp;

  int testsRun   = 0;
  int testsFail  = 0;
  int cyc        = 0;
  int memDelay   = 0;
  int memWait    = 0;
  bit memRespond = 1'b1;
  bit strayAck   = 1'b0;
  logic [DW-1:0] lastLs;
  int c0;

  mem_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .ls_req_i    (ls_req_i),
    .ls_we_i     (ls_we_i),
    .ls_addr_i   (ls_addr_i),
    .ls_wdata_i  (ls_wdata_i),
    .ls_ack_o    (ls_ack_o),
    .ls_rdata_o  (ls_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .grant_o     (grant_o),
    .timeout_o   (timeout_o)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memModel(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hABCD;
    return (a ^ 16'h5A00) + 16'h0101;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Memory acks after memDelay cycles of mem_req_o unless told to stay silent.
  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mem_req_o) begin
        if (memRespond && (memWait == memDelay)) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = memModel(mem_addr_o);
        end else begin
          mem_ack_i   = 1'b0;
          mem_rdata_i = '0;
        end
        memWait++;
      end else begin
        mem_ack_i   = strayAck;
        mem_rdata_i = strayAck ? 16'hDEAD : '0;
        memWait     = 0;
      end
    end
  end

  // Scoreboard pop on every requester acknowledge.
  always @(negedge clk_i) begin
    if (if_ack_o || ls_ack_o) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousAck", {30'd0, if_ack_o, ls_ack_o}, 32'd0);
      end else begin
        curExp = expQ.pop_front();
        checkOutput("ackOwner", {31'd0, ls_ack_o}, {31'd0, curExp.owner});
        checkOutput("singleAck", {31'd0, if_ack_o & ls_ack_o}, 32'd0);
        checkOutput("grant", {31'd0, grant_o}, {31'd0, curExp.owner});
        checkOutput("rdata", curExp.owner ? ls_rdata_o : if_rdata_o, curExp.rdata);
        checkOutput("timeout", {31'd0, timeout_o}, {31'd0, curExp.timeout});
        if (curExp.expCycle >= 0) checkOutput("ackCycle", cyc, curExp.expCycle);
      end
    end else begin
      checkOutput("strayTimeout", {31'd0, timeout_o}, 32'd0);
    end
  end

  task automatic pushExp(input logic owner, input logic [DW-1:0] rdata, input logic to, input int ec);
    exp_t e;
    e.owner    = owner;
    e.rdata    = rdata;
    e.timeout  = to;
    e.expCycle = ec;
    expQ.push_back(e);
  endtask

  task automatic runFetch(input logic [AW-1:0] addr);
    bit seen = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = addr;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      seen = if_ack_o;
    end
    if (!seen) checkOutput("ifAckWait", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0;
  endtask

  task automatic runLs(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit seen = 1'b0;
    ls_req_i   = 1'b1;
    ls_we_i    = we;
    ls_addr_i  = addr;
    ls_wdata_i = wdata;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      seen = ls_ack_o;
    end
    if (!seen) checkOutput("lsAckWait", 32'd0, 32'd1);
    @(posedge clk_i);
    #1;
    ls_req_i = 1'b0;
    ls_we_i  = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_memReq"}, {31'd0, mem_req_o}, 32'd0);
    checkOutput({tag, "_memWe"}, {31'd0, mem_we_o}, 32'd0);
    checkOutput({tag, "_memAddr"}, {16'd0, mem_addr_o}, 32'd0);
    checkOutput({tag, "_memWdata"}, {16'd0, mem_wdata_o}, 32'd0);
    checkOutput({tag, "_ifAck"}, {31'd0, if_ack_o}, 32'd0);
    checkOutput({tag, "_lsAck"}, {31'd0, ls_ack_o}, 32'd0);
    checkOutput({tag, "_ifRdata"}, {16'd0, if_rdata_o}, 32'd0);
    checkOutput({tag, "_lsRdata"}, {16'd0, ls_rdata_o}, 32'd0);
    checkOutput({tag, "_grant"}, {31'd0, grant_o}, 32'd0);
    checkOutput({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
  endtask

  task automatic applyStimulus();
    arst_ni    = 1'b0;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    ls_req_i   = 1'b0;
    ls_we_i    = 1'b0;
    ls_addr_i  = '0;
    ls_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checkAllZero("reset");
    arst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Stray memory ack while idle must be ignored.
    strayAck = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      checkOutput("strayMemReq", {31'd0, mem_req_o}, 32'd0);
      checkOutput("strayGrant", {31'd0, grant_o}, 32'd0);
    end
    strayAck = 1'b0;
    @(posedge clk_i);
    #1;

    // Tie after reset: fetch, load/store, fetch.
    memDelay = 0;
    c0 = cyc;
    pushExp(1'b0, memModel(16'h0040), 1'b0, c0 + 2);
    pushExp(1'b1, memModel(16'h0050), 1'b0, c0 + 4);
    pushExp(1'b0, memModel(16'h0044), 1'b0, c0 + 6);
    fork
      begin
        runFetch(16'h0040);
        runFetch(16'h0044);
      end
      runLs(1'b0, 16'h0050, '0);
    join

    // Single fetch with immediate memory ack.
    pushExp(1'b0, 16'hABCD, 1'b0, cyc + 2);
    fork
      runFetch(16'h0010);
      begin
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("fetchReq", {31'd0, mem_req_o}, 32'd1);
        checkOutput("fetchAddr", {16'd0, mem_addr_o}, 32'h10);
        checkOutput("fetchWe", {31'd0, mem_we_o}, 32'd0);
      end
    join

    // Load to give ls_rdata_o a known value, then a delayed store.
    lastLs = memModel(16'h0030);
    pushExp(1'b1, lastLs, 1'b0, -1);
    runLs(1'b0, 16'h0030, '0);
    memDelay = 3;
    pushExp(1'b1, lastLs, 1'b0, cyc + 5);
    fork
      runLs(1'b1, 16'h0020, 16'h1234);
      begin
        @(posedge clk_i);
        repeat (4) begin
          @(negedge clk_i);
          checkOutput("storeReq", {31'd0, mem_req_o}, 32'd1);
          checkOutput("storeWe", {31'd0, mem_we_o}, 32'd1);
          checkOutput("storeAddr", {16'd0, mem_addr_o}, 32'h20);
          checkOutput("storeWdata", {16'd0, mem_wdata_o}, 32'h1234);
        end
      end
    join

    // Memory never answers: abort after the wait limit.
    memRespond = 1'b0;
    memDelay   = 0;
    pushExp(1'b1, '0, 1'b1, cyc + MAXW + 2);
    runLs(1'b0, 16'h0060, '0);
    memRespond = 1'b1;
    @(negedge clk_i);
    checkOutput("idleAfterTimeout", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk_i);
    #1;
    pushExp(1'b0, memModel(16'h0070), 1'b0, cyc + 2);
    runFetch(16'h0070);

    // Reset in the middle of a fetch drops it without an ack.
    memRespond = 1'b0;
    if_req_i   = 1'b1;
    if_addr_i  = 16'h0080;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    arst_ni = 1'b0;
    #1;
    checkAllZero("midReset");
    if_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    arst_ni    = 1'b1;
    memRespond = 1'b1;
    @(posedge clk_i);
    #1;
    c0 = cyc;
    pushExp(1'b0, memModel(16'h0090), 1'b0, c0 + 2);
    pushExp(1'b1, memModel(16'h00A0), 1'b0, c0 + 4);
    fork
      runFetch(16'h0090);
      runLs(1'b0, 16'h00A0, '0);
    join
  endtask

  initial begin
    applyStimulus();
    repeat (3) @(posedge clk_i);
    checkOutput("drain", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared memory port of the simple processor. It accepts word requests from the instruction fetch stage (read-only) and the load/store unit (read/write), grants one at a time with round-robin fairness, and drives the memory request/acknowledge handshake. It also returns read data and an acknowledge to the winning requester, and aborts any transaction that exceeds a wait limit.

## Interface
- ADDR_WIDTH, default sp_pkg::ADDR_WIDTH, address width of all ports
- DATA_WIDTH, default sp_pkg::DATA_WIDTH, data width of all ports
- MAX_WAIT, default 15, cycles a granted transaction waits for mem_ack_i before abort (legal range 1..255)

- clk_i  in  1  clock, all state updates on rising edge
- arst_ni  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch read request, held until if_ack_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_WIDTH  fetch data, valid while if_ack_o=1
- ls_req_i  in  1  load/store request, held until ls_ack_o
- ls_we_i  in  1  1=write, 0=read
- ls_addr_i  in  ADDR_WIDTH  load/store address
- ls_wdata_i  in  DATA_WIDTH  store data
- ls_ack_o  out  1  one-cycle load/store completion pulse
- ls_rdata_o  out  DATA_WIDTH  load data, valid while ls_ack_o=1
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_ack_i  in  1  memory completion
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid with mem_ack_i
- grant_o  out  1  current or last owner: 0=fetch, 1=load/store
- timeout_o  out  1  one-cycle pulse on abort

## Operation
- FSM states: ARB_IDLE, ARB_IF, ARB_LS.
- ARB_IDLE:
  - If only one request is active, grant it.
  - If both are active, grant the requester that was not the last grantee.
  - The grant captures addr/we/wdata into registers. Fetch always uses we=0.
  - last_grant updates on grant.
- ARB_IF and ARB_LS:
  - mem_req_o=1 and the mem_* outputs come from the captured registers. They are stable for the whole transaction.
  - Requester inputs are ignored until completion.
- Completion happens on mem_ack_i=1 in a grant state:
  - mem_rdata_i is registered into the owner's rdata_o.
  - The owner's ack_o pulses the next cycle.
  - The FSM returns to ARB_IDLE.
- Wait counter:
  - Clears on grant and increments each grant-state cycle without an ack.
  - When it equals MAX_WAIT with no ack, the transaction aborts. The owner's ack_o and timeout_o pulse the next cycle, rdata_o='0, and the FSM returns to ARB_IDLE.
  - An ack in the same cycle as reaching MAX_WAIT is a normal completion; no timeout.
- Ack-cycle masking: in the cycle an ack_o is high, that requester's req is ignored. The other requester may be granted in that cycle.
- mem_ack_i in ARB_IDLE is ignored.
- rdata_o holds its value until the next completion for that requester. A write completion leaves ls_rdata_o unchanged.
- Reset values:
  - All outputs 0, FSM ARB_IDLE, counter 0.
  - last_grant = load/store, so fetch wins the first tie.
  - Reset mid-transaction drops the transaction with no ack.

## Timing
- Request sampled at edge E0 → mem_req_o high from cycle 1.
- mem_ack_i in cycle k → ack_o in cycle k+1.
- Minimum latency is req to ack_o = 2 cycles, when memory acks in cycle 1.
- Peak throughput for alternating requesters is one transaction per 2 cycles; for a single requester, one per 3 cycles.
- Timeout abort: ack_o and timeout_o appear MAX_WAIT+1 cycles after grant.
- All outputs are registered except the mem_* fields, which are driven directly from registers (no combinational input-to-output paths).

## Structure
- Add to sp_pkg:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_IF, ARB_LS}
  - typedef enum logic {REQ_IF, REQ_LS} requester_e
  - localparam ARB_MAX_WAIT_DEFAULT = 15
- One sub-module, arb_wait_timer:
  - Ports: clear, enable, expired.
  - Counter width is $clog2(MAX_WAIT+1).
  - Instantiated once.

## Test plan
- Single fetch: if_req_i=1, if_addr_i=0x10, memory acks in cycle 1 with rdata 0xABCD → mem_addr_o=0x10, mem_we_o=0, if_ack_o at cycle 2 with if_rdata_o=0xABCD.
- Tie after reset: both requests in cycle 0 → fetch granted first, then load/store, then fetch (grant_o sequence 0,1,0 over three transactions).
- Store: ls_we_i=1, addr 0x20, wdata 0x1234, memory ack delayed 3 cycles → mem_* stable for 4 cycles, ls_ack_o once, ls_rdata_o unchanged.
- Timeout with MAX_WAIT=4: memory never acks → ls_ack_o and timeout_o pulse 5 cycles after grant, ls_rdata_o=0, FSM idle, next fetch served normally.
- Reset mid-transaction: arst_ni low in cycle 2 of a fetch → all outputs 0 immediately, no if_ack_o, and fetch wins the next tie.
- Stray mem_ack_i in idle → no ack_o, no state change.
